gba_timers: RTL and testbench
=============================

// Module: gba_timers
// PURPOSE
//  Four 16-bit GBA hardware timers (TM0-TM3), upstream of interrupt_controller.
//  Each timer has a reload value, a prescaler (1/64/256/1024) or cascade (count-up) mode, and a start bit.
//  On overflow a timer emits a one-cycle IRQ pulse into interrupt_controller's timer0..timer3 inputs.
//  It also emits a one-cycle overflow pulse for the sound FIFO logic.
// PARAMETERS
//  TICK_DIV  1  system clocks per GBA base tick (1 = count every clock); must be >= 1
// PORTS
//  clock         in   1   system clock
//  reset         in   1   asynchronous, active-high
//  reload_we     in   4   one-hot write strobe, TMxCNT_L (reload) of timer x
//  reload_wdata  in   16  reload value written on reload_we
//  ctrl_we       in   4   one-hot write strobe, TMxCNT_H (control) of timer x
//  ctrl_wdata    in   8   [1:0] prescale sel, [2] count-up, [6] irq_en, [7] start; other bits ignored
//  count_rd      out  64  live counters, {TM3,TM2,TM1,TM0}, 16 bits each
//  ctrl_rd       out  32  control readback, {TM3..TM0} x 8 bits; unused bits read 0
//  timer_irq     out  4   one-cycle pulse: overflow of timer x with irq_en set -> interrupt_controller timer0..3
//  overflow      out  4   one-cycle pulse on every overflow of timer x, regardless of irq_en
// BEHAVIOUR
//  Reset
//   - All counters, reload values, control regs and prescalers = 0.
//   - timer_irq = 0, overflow = 0. Base-tick divider = 0.
//  Base tick
//   - Free-running divider produces tick=1 one clock in every TICK_DIV.
//   - TICK_DIV=1 -> tick is constantly 1.
//  Prescaler
//   - Each timer has its own 10-bit prescale counter, which advances on tick while started.
//   - Prescale period by sel: 00 -> 1, 01 -> 64, 10 -> 256, 11 -> 1024.
//   - The timer increments on the tick where its prescale counter reaches period-1; the prescale counter then wraps to 0.
//  Cascade
//   - count-up=1 applies to timers 1-3 only and is ignored (reads back as stored) for TM0.
//   - A cascaded timer increments only in the same clock as timer x-1 overflows; its prescaler is unused.
//   - The chain ripples combinationally: TM0..TM3 can all overflow in one clock.
//   - A stopped timer x-1 never overflows, so it never clocks timer x.
//  Increment / overflow
//   - Count 0xFFFF incrementing -> count <= reload, overflow[x] = 1 on the next clock for exactly 1 cycle.
//   - timer_irq[x] = overflow condition & irq_en; registered with the same timing as overflow[x].
//   - Reload 0xFFFF with period 1 -> overflow every tick (a continuous pulse train when TICK_DIV=1).
//  Control writes (take effect on the clock edge of the strobe)
//   - start 0->1: count <= reload, prescaler <= 0. First increment comes one full period later (no increment on the write cycle).
//   - start 1->0: count frozen, readable. No further pulses.
//   - start 1->1: settings update and the count continues; the prescaler is NOT cleared.
//  Reload writes
//   - A write stores a new reload value only; the count is unaffected.
//   - Overflow in the same clock as reload_we[x] -> the count loads the NEW reload_wdata.
//   - Control write start 0->1 in the same clock as reload_we[x] -> the count loads the NEW reload_wdata.
//  Readback
//   - count_rd and ctrl_rd are combinational from the registers (no read latency).
//  Reset mid-operation: all state returns to reset values immediately; no pending pulse survives.
// TESTING
//  1. TICK_DIV=1; reload=0xFFFC; ctrl=0xC0 (start, irq, /1)
//     -> overflow/timer_irq[0] pulse 4 clocks after the write edge, then every 4 clocks; count wraps to 0xFFFC.
//  2. reload=0xFFFF; sel=01; start TM1 with irq_en=0
//     -> overflow[1] every 64 clocks; timer_irq[1] stays 0.
//  3. Cascade: TM0 reload 0xFFFF /1 start; TM1 reload 0xFFFE count-up+irq start
//     -> timer_irq[1] every 2 clocks, coincident with overflow[0].
//  4. Stop TM2 mid-count at 0x1234 (ctrl start=0) -> count_rd[47:32] holds 0x1234; no pulses.
//     Restart -> count = reload.
//  5. TM0 reload=0xFFFF, running /1; write reload=0x8000 in the clock of an overflow -> count becomes 0x8000.
//  6. Assert reset while TM0-TM3 run with pulses pending -> all outputs 0 immediately; counts 0.

Source files
------------

// File: rtl/gba_timers.sv
// Four 16-bit GBA timers (TM0-TM3) with reload, prescaler or cascade
// counting, and one-cycle overflow / IRQ pulses for the sound FIFO and
// interrupt controller.
//
// A control write that clears start stops the timer at that edge. The count
// it shows is frozen at its value before the write, and that clock makes no
// increment or pulse. Other control writes take effect from the next clock.
module gba_timers #(
  parameter int TICK_DIV = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  reload_we,
  input  logic [15:0] reload_wdata,
  input  logic [3:0]  ctrl_we,
  input  logic [7:0]  ctrl_wdata,
  output logic [63:0] count_rd,
  output logic [31:0] ctrl_rd,
  output logic [3:0]  timer_irq,
  output logic [3:0]  overflow
);

  logic tick;

  generate
    if (TICK_DIV <= 1) begin : g_tick_const
      assign tick = 1'b1;
    end else begin : g_tick_div
      localparam int DIV_W = $clog2(TICK_DIV);
      localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
      logic [DIV_W-1:0] div_q;

      // Free-running base-tick divider: one tick per TICK_DIV clocks
      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          div_q <= '0;
        end else if (div_q == DIV_LAST) begin
          div_q <= '0;
        end else begin
          div_q <= div_q + DIV_W'(1);
        end
      end

      assign tick = (div_q == DIV_LAST);
    end
  endgenerate

  // Prescale count at which the timer increments (period - 1)
  function automatic logic [9:0] last_tap(input logic [1:0] sel);
    case (sel)
      2'd0:    last_tap = 10'd0;
      2'd1:    last_tap = 10'd63;
      2'd2:    last_tap = 10'd255;
      default: last_tap = 10'd1023;
    endcase
  endfunction

  logic [15:0] count_q  [4];
  logic [15:0] reload_q [4];
  logic [7:0]  ctrl_q   [4];
  logic [9:0]  presc_q  [4];
  logic [3:0]  ovf_p1;
  logic [3:0]  irq_p1;

  logic [15:0] reload_nxt [4];
  logic [3:0]  start_c;
  logic [3:0]  inc_c;
  logic [3:0]  ovf_c;
  logic [3:0]  irq_en_c;
  logic [3:0]  presc_adv_c;
  logic [3:0]  presc_wrap_c;

  // Per-timer increment decision; the overflow carry ripples TM0 -> TM3 in one clock
  always_comb begin
    logic carry;
    logic run;
    logic casc;
    carry        = 1'b0;
    run          = 1'b0;
    casc         = 1'b0;
    reload_nxt   = '{default: '0};
    start_c      = '0;
    inc_c        = '0;
    ovf_c        = '0;
    irq_en_c     = '0;
    presc_adv_c  = '0;
    presc_wrap_c = '0;
    for (int i = 0; i < 4; i++) begin
      reload_nxt[i]   = reload_we[i] ? reload_wdata : reload_q[i];
      start_c[i]      = ctrl_we[i] & ctrl_wdata[7] & ~ctrl_q[i][7];
      run             = ctrl_q[i][7] & ~(ctrl_we[i] & ~ctrl_wdata[7]);
      casc            = (i != 0) && ctrl_q[i][2];
      irq_en_c[i]     = ctrl_q[i][6];
      presc_wrap_c[i] = (presc_q[i] == last_tap(ctrl_q[i][1:0]));
      presc_adv_c[i]  = run & ~casc & tick;
      inc_c[i]        = run & (casc ? carry : (tick & presc_wrap_c[i]));
      ovf_c[i]        = inc_c[i] & (count_q[i] == 16'hFFFF);
      carry           = ovf_c[i];
    end
  end

  // Timer state: registers, counters, prescalers and registered pulses (stage p1)
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        count_q[i]  <= '0;
        reload_q[i] <= '0;
        ctrl_q[i]   <= '0;
        presc_q[i]  <= '0;
      end
      ovf_p1 <= '0;
      irq_p1 <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (reload_we[i]) begin
          reload_q[i] <= reload_wdata;
        end
        if (ctrl_we[i]) begin
          ctrl_q[i] <= ctrl_wdata & 8'hC7;
        end
        if (start_c[i]) begin
          count_q[i] <= reload_nxt[i];
          presc_q[i] <= '0;
        end else begin
          if (inc_c[i]) begin
            count_q[i] <= (count_q[i] == 16'hFFFF) ? reload_nxt[i] : count_q[i] + 16'd1;
          end
          if (presc_adv_c[i]) begin
            presc_q[i] <= presc_wrap_c[i] ? 10'd0 : presc_q[i] + 10'd1;
          end
        end
      end
      ovf_p1 <= ovf_c;
      irq_p1 <= ovf_c & irq_en_c;
    end
  end

  // Combinational readback of counters and control registers
  always_comb begin
    count_rd = '0;
    ctrl_rd  = '0;
    for (int i = 0; i < 4; i++) begin
      count_rd[i*16 +: 16] = count_q[i];
      ctrl_rd[i*8 +: 8]    = ctrl_q[i];
    end
  end

  assign overflow  = ovf_p1;
  assign timer_irq = irq_p1;

endmodule

// File: tb/tb_gba_timers.sv
// Testbench for gba_timers: directed scenarios plus randomized register
// traffic checked against a behavioural timer model.
module tb_gba_timers;

  logic        clock;
  logic        reset;
  logic [3:0]  reload_we;
  logic [15:0] reload_wdata;
  logic [3:0]  ctrl_we;
  logic [7:0]  ctrl_wdata;
  logic [63:0] count_rd;
  logic [31:0] ctrl_rd;
  logic [3:0]  timer_irq;
  logic [3:0]  overflow;

  int checks;
  int failures;

  gba_timers #(.TICK_DIV(1)) dut (
    .clock        (clock),
    .reset        (reset),
    .reload_we    (reload_we),
    .reload_wdata (reload_wdata),
    .ctrl_we      (ctrl_we),
    .ctrl_wdata   (ctrl_wdata),
    .count_rd     (count_rd),
    .ctrl_rd      (ctrl_rd),
    .timer_irq    (timer_irq),
    .overflow     (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural model state
  logic [15:0] m_count  [4];
  logic [15:0] m_reload [4];
  logic [7:0]  m_ctrl   [4];
  int          m_presc  [4];
  logic [3:0]  m_ovf;
  logic [3:0]  m_irq;

  task automatic model_reset();
    for (int t = 0; t < 4; t++) begin
      m_count[t] = '0; m_reload[t] = '0; m_ctrl[t] = '0; m_presc[t] = 0;
    end
    m_ovf = '0;
    m_irq = '0;
  endtask

  // One clock of the timer rules with the inputs currently driven (tick every clock)
  task automatic model_step();
    logic carry;
    logic [3:0] ovf;
    carry = 1'b0;
    ovf = '0;
    for (int t = 0; t < 4; t++) begin
      logic [15:0] nrel;
      bit cascade;
      bit bump;
      int period;
      nrel = reload_we[t] ? reload_wdata : m_reload[t];
      cascade = (t != 0) && m_ctrl[t][2];
      case (m_ctrl[t][1:0])
        2'd0: period = 1;
        2'd1: period = 64;
        2'd2: period = 256;
        default: period = 1024;
      endcase
      bump = 1'b0;
      if (ctrl_we[t] && ctrl_wdata[7] && !m_ctrl[t][7]) begin
        m_count[t] = nrel;
        m_presc[t] = 0;
      end else if (m_ctrl[t][7] && !(ctrl_we[t] && !ctrl_wdata[7])) begin
        if (cascade) begin
          bump = carry;
        end else begin
          bump = (m_presc[t] == period - 1);
          m_presc[t] = bump ? 0 : (m_presc[t] + 1) % 1024;
        end
        if (bump) begin
          if (m_count[t] == 16'hFFFF) begin
            m_count[t] = nrel;
            ovf[t] = 1'b1;
          end else begin
            m_count[t] = m_count[t] + 16'd1;
          end
        end
      end
      carry = ovf[t];
      m_irq[t] = ovf[t] & m_ctrl[t][6];
      if (reload_we[t]) m_reload[t] = reload_wdata;
      if (ctrl_we[t]) m_ctrl[t] = ctrl_wdata & 8'hC7;
    end
    m_ovf = ovf;
  endtask

  // Advance one clock: step the model, then sample 1 time unit after the edge
  task automatic cycle();
    model_step();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    reload_we = '0; reload_wdata = '0; ctrl_we = '0; ctrl_wdata = '0;
  endtask

  task automatic write_reload(input int t, input logic [15:0] v);
    reload_we = 4'(1 << t); reload_wdata = v;
    cycle();
    idle_inputs();
  endtask

  task automatic write_ctrl(input int t, input logic [7:0] v);
    ctrl_we = 4'(1 << t); ctrl_wdata = v;
    cycle();
    idle_inputs();
  endtask

  task automatic apply_reset();
    idle_inputs();
    reset = 1'b1;
    @(posedge clock);
    #1;
    model_reset();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (count_rd !== 64'h0) begin failures++; $display("FAIL reset_count actual=%h required=%h", count_rd, 64'h0); end
    checks++;
    if (ctrl_rd !== 32'h0) begin failures++; $display("FAIL reset_ctrl actual=%h required=%h", ctrl_rd, 32'h0); end
    checks++;
    if (overflow !== 4'h0) begin failures++; $display("FAIL reset_ovf actual=%h required=%h", overflow, 4'h0); end
    checks++;
    if (timer_irq !== 4'h0) begin failures++; $display("FAIL reset_irq actual=%h required=%h", timer_irq, 4'h0); end
  endtask

  task automatic test_div1_irq();
    apply_reset();
    write_reload(0, 16'hFFFC);
    write_ctrl(0, 8'hC0);
    checks++;
    if (count_rd[15:0] !== 16'hFFFC) begin failures++; $display("FAIL t1_start_count actual=%h required=%h", count_rd[15:0], 16'hFFFC); end
    checks++;
    if (ctrl_rd[7:0] !== 8'hC0) begin failures++; $display("FAIL t1_ctrl_rd actual=%h required=%h", ctrl_rd[7:0], 8'hC0); end
    for (int k = 1; k <= 12; k++) begin
      logic [15:0] exp_cnt;
      logic exp_p;
      cycle();
      exp_cnt = 16'hFFFC + 16'(k % 4);
      exp_p = (k % 4 == 0);
      checks++;
      if (count_rd[15:0] !== exp_cnt) begin failures++; $display("FAIL t1_count k=%0d actual=%h required=%h", k, count_rd[15:0], exp_cnt); end
      checks++;
      if (overflow[0] !== exp_p) begin failures++; $display("FAIL t1_ovf k=%0d actual=%b required=%b", k, overflow[0], exp_p); end
      checks++;
      if (timer_irq[0] !== exp_p) begin failures++; $display("FAIL t1_irq k=%0d actual=%b required=%b", k, timer_irq[0], exp_p); end
    end
  endtask

  task automatic test_prescale64();
    apply_reset();
    write_reload(1, 16'hFFFF);
    write_ctrl(1, 8'h81);
    for (int k = 1; k <= 130; k++) begin
      logic exp_p;
      cycle();
      exp_p = (k % 64 == 0);
      checks++;
      if (overflow[1] !== exp_p) begin failures++; $display("FAIL t2_ovf k=%0d actual=%b required=%b", k, overflow[1], exp_p); end
      checks++;
      if (timer_irq[1] !== 1'b0) begin failures++; $display("FAIL t2_irq k=%0d actual=%b required=0", k, timer_irq[1]); end
      checks++;
      if (count_rd[31:16] !== 16'hFFFF) begin failures++; $display("FAIL t2_count k=%0d actual=%h required=ffff", k, count_rd[31:16]); end
    end
  endtask

  task automatic test_cascade();
    apply_reset();
    write_reload(0, 16'hFFFF);
    write_ctrl(0, 8'h80);
    write_reload(1, 16'hFFFE);
    write_ctrl(1, 8'hC4);
    for (int k = 1; k <= 10; k++) begin
      logic exp_p;
      logic [15:0] exp_cnt;
      cycle();
      exp_p = (k % 2 == 0);
      exp_cnt = exp_p ? 16'hFFFE : 16'hFFFF;
      checks++;
      if (overflow[0] !== 1'b1) begin failures++; $display("FAIL t3_ovf0 k=%0d actual=%b required=1", k, overflow[0]); end
      checks++;
      if (timer_irq[1] !== exp_p) begin failures++; $display("FAIL t3_irq1 k=%0d actual=%b required=%b", k, timer_irq[1], exp_p); end
      checks++;
      if (count_rd[31:16] !== exp_cnt) begin failures++; $display("FAIL t3_count1 k=%0d actual=%h required=%h", k, count_rd[31:16], exp_cnt); end
    end
  endtask

  task automatic test_stop_restart();
    apply_reset();
    write_reload(2, 16'h1200);
    write_ctrl(2, 8'hC0);
    for (int k = 0; k < 16'h34; k++) cycle();
    checks++;
    if (count_rd[47:32] !== 16'h1234) begin failures++; $display("FAIL t4_run_count actual=%h required=1234", count_rd[47:32]); end
    write_ctrl(2, 8'h40);
    for (int k = 0; k < 10; k++) begin
      cycle();
      checks++;
      if (count_rd[47:32] !== 16'h1234) begin failures++; $display("FAIL t4_hold k=%0d actual=%h required=1234", k, count_rd[47:32]); end
      checks++;
      if ({overflow[2], timer_irq[2]} !== 2'b00) begin failures++; $display("FAIL t4_pulse k=%0d actual=%b required=00", k, {overflow[2], timer_irq[2]}); end
    end
    write_ctrl(2, 8'h80);
    checks++;
    if (count_rd[47:32] !== 16'h1200) begin failures++; $display("FAIL t4_restart actual=%h required=1200", count_rd[47:32]); end
  endtask

  task automatic test_reload_on_overflow();
    apply_reset();
    write_reload(0, 16'hFFFF);
    write_ctrl(0, 8'h80);
    for (int k = 0; k < 3; k++) cycle();
    write_reload(0, 16'h8000);
    checks++;
    if (count_rd[15:0] !== 16'h8000) begin failures++; $display("FAIL t5_count actual=%h required=8000", count_rd[15:0]); end
    checks++;
    if (overflow[0] !== 1'b1) begin failures++; $display("FAIL t5_ovf actual=%b required=1", overflow[0]); end
    cycle();
    checks++;
    if (count_rd[15:0] !== 16'h8001) begin failures++; $display("FAIL t5_next actual=%h required=8001", count_rd[15:0]); end
  endtask

  task automatic test_random();
    apply_reset();
    for (int k = 0; k < 1500; k++) begin
      int r;
      int t;
      logic [7:0] c;
      idle_inputs();
      r = $urandom_range(0, 9);
      t = $urandom_range(0, 3);
      if (r == 0) begin
        reload_we = 4'(1 << t);
        reload_wdata = ($urandom_range(0, 3) == 0) ? 16'($urandom) : (16'hFFF0 | 16'($urandom_range(0, 15)));
      end else if (r == 1) begin
        c = 8'($urandom);
        if ($urandom_range(0, 3) != 0) c[1:0] = 2'd0;
        if ($urandom_range(0, 2) != 0) c[7] = 1'b1;
        ctrl_we = 4'(1 << t);
        ctrl_wdata = c;
      end else if (r == 2) begin
        reload_we = 4'(1 << t);
        reload_wdata = 16'hFFF0 | 16'($urandom_range(0, 15));
        ctrl_we = 4'(1 << t);
        ctrl_wdata = 8'hC0 | 8'($urandom_range(0, 7) & 4);
      end
      cycle();
      checks++;
      if (count_rd !== {m_count[3], m_count[2], m_count[1], m_count[0]}) begin
        failures++; $display("FAIL rnd_count k=%0d actual=%h required=%h", k, count_rd, {m_count[3], m_count[2], m_count[1], m_count[0]});
      end
      checks++;
      if (ctrl_rd !== {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]}) begin
        failures++; $display("FAIL rnd_ctrl k=%0d actual=%h required=%h", k, ctrl_rd, {m_ctrl[3], m_ctrl[2], m_ctrl[1], m_ctrl[0]});
      end
      checks++;
      if (overflow !== m_ovf) begin failures++; $display("FAIL rnd_ovf k=%0d actual=%h required=%h", k, overflow, m_ovf); end
      checks++;
      if (timer_irq !== m_irq) begin failures++; $display("FAIL rnd_irq k=%0d actual=%h required=%h", k, timer_irq, m_irq); end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int t = 0; t < 4; t++) write_reload(t, 16'hFFFF);
    write_ctrl(0, 8'hC0);
    write_ctrl(1, 8'hC4);
    write_ctrl(2, 8'hC0);
    write_ctrl(3, 8'hC0);
    cycle();
    checks++;
    if (overflow !== 4'hF) begin failures++; $display("FAIL t6_pre_ovf actual=%h required=f", overflow); end
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (overflow !== 4'h0) begin failures++; $display("FAIL t6_ovf actual=%h required=0", overflow); end
    checks++;
    if (timer_irq !== 4'h0) begin failures++; $display("FAIL t6_irq actual=%h required=0", timer_irq); end
    checks++;
    if (count_rd !== 64'h0) begin failures++; $display("FAIL t6_count actual=%h required=0", count_rd); end
    checks++;
    if (ctrl_rd !== 32'h0) begin failures++; $display("FAIL t6_ctrl actual=%h required=0", ctrl_rd); end
    apply_reset();
    cycle();
    checks++;
    if ({count_rd, overflow} !== 68'h0) begin failures++; $display("FAIL t6_after actual=%h required=0", {count_rd, overflow}); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_div1_irq();
    test_prescale64();
    test_cascade();
    test_stop_restart();
    test_reload_on_overflow();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
